dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the RISC-V core load/store port and an external loader/debug port. It sits between the datapath memory interface (`wr`, `rd`, 9-bit `addr`, 32-bit write/read data) and the data memory. It provides round-robin fairness, registered memory-side outputs and read-data routing with a tag. Each requester can issue one access per cycle, and a stall signal is returned to the core.

## Interface
- `DATA_W`, 32, data width of both requesters and memory
- `ADDR_W`, 9, word address width
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `core_req` in 1: core access request; hold with payload stable until `core_gnt`
- `core_we` in 1: 1 = write, 0 = read
- `core_addr` in ADDR_W: core address
- `core_wdata` in DATA_W: core write data
- `core_gnt` out 1: one-cycle pulse, payload captured this cycle
- `core_stall` out 1: `core_req & ~core_gnt`, combinational
- `core_rvalid` out 1: core read data valid
- `core_rdata` out DATA_W: core read data
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_gnt`, `ext_rvalid`, `ext_rdata`: same directions, widths and rules for the external port
- `mem_wr` out 1: memory write strobe, registered
- `mem_rd` out 1: memory read strobe, registered
- `mem_addr` out ADDR_W: registered address
- `mem_wr_data` out DATA_W: registered write data
- `mem_rd_data` in DATA_W: valid exactly 1 cycle after `mem_rd`
- `conflict_cnt` out 16: only with `DMEM_ARB_STATS_EN`

## Operation
- Each cycle, the arbiter picks at most one winner among the asserted requests.
- If only one requester asserts `req`, it wins.
- If both assert `req`, the winner is the port not granted most recently, tracked by the `last` pointer.
- The `last` pointer updates to the winner on every grant and holds when there is no grant.
- `gnt` is combinational in the winning cycle. The loser sees `gnt=0` and must keep `req` and its payload stable.
- On a grant, the next edge registers `mem_wr=we`, `mem_rd=~we`, `mem_addr` and `mem_wr_data`.
- With no grant, `mem_wr`/`mem_rd` are 0 the next cycle. `mem_addr`/`mem_wr_data` hold their previous values.
- Read routing pipeline:
  - Tag stage 1 is captured with the `mem_*` registers and holds one of NONE/CORE/EXT.
  - Tag stage 2 is that value delayed by one cycle.
  - `x_rvalid` = (stage-2 tag == x). `x_rdata` = `mem_rd_data` when x owns stage 2, else 0.
- A write produces no `rvalid`; the grant is its only acknowledgement.
- Back-to-back accesses are fully pipelined, at one grant per cycle.
- If the core and the external port issue a read and a write to the same address on consecutive grants, the order in memory is grant order. No forwarding.

## Timing
- Read latency: `gnt` in cycle N, `mem_rd` in N+1, `rvalid` and `rdata` in N+2.
- Write: `gnt` in N, `mem_wr` in N+1.
- Worst-case core wait under continuous external traffic is 1 cycle, because requests alternate.
- Reset values:
  - `mem_wr`, `mem_rd`: 0
  - `mem_addr`, `mem_wr_data`: 0
  - Both tag stages: NONE, so `rvalid`=0 and `rdata`=0
  - `last` = EXT, so the core wins the first contention
  - `conflict_cnt`: 0
- `gnt` is forced to 0 while `reset`=1.
- Reset mid-operation: in-flight tags are cleared. A read issued before reset never produces `rvalid`, even if memory returns data afterwards.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Adds port `conflict_cnt[15:0]`.
  - Increments in every cycle where both `req` are high.
  - Saturates at 0xFFFF and clears on reset.
- `DMEM_ARB_STATS_EN` undefined: the port and counter do not exist, and all other behaviour is identical.

## Structure
- Package `dmem_arb_pkg` contains:
  - Enum `owner_t` {OWN_NONE, OWN_CORE, OWN_EXT}
  - Localparams `DMEM_ADDR_W=9` and `DMEM_DATA_W=32`
  - Localparam `CONFLICT_CNT_W=16`
- Sub-module `rr_arb2`, the two-way round-robin picker:
  - Inputs: `req[1:0]`, `last`
  - Output: one-hot `gnt[1:0]`
  - Purely combinational
  - The `last` register lives in the parent.

## Test plan
- Reset, then `core_req` read to addr 0x005 while memory holds 0xDEADBEEF at 0x005:
  - `core_gnt` in cycle 0, `mem_rd` with `mem_addr`=0x005 in cycle 1.
  - `core_rvalid` with 0xDEADBEEF in cycle 2.
  - `ext_rvalid` stays 0 throughout.
- Both ports request for 4 consecutive cycles, each re-requesting right after its grant:
  - Grants alternate CORE, EXT, CORE, EXT.
  - `core_stall`=1 only in the EXT cycles.
  - `conflict_cnt`=4 when stats are enabled.
- `ext_we`=1 writes 0x12345678 to 0x1FF in cycle N, and `core_req` reads 0x1FF in cycle N+1:
  - `mem_wr` in N+1, `mem_rd` in N+2.
  - `core_rdata`=0x12345678 in N+3.
- Core read granted in cycle N, `reset`=1 in N+1:
  - `core_rvalid` stays 0 in N+2 despite memory data.
  - All `mem_*` outputs are 0 in N+2.
- External port streams 3 reads to 0x010, 0x011, 0x012 with no core traffic:
  - 3 consecutive grants.
  - `ext_rvalid` high for 3 consecutive cycles, with the data in order.
- Stats enabled, forced continuous contention for 70000 cycles:
  - `conflict_cnt` saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W    = 9;
  localparam int DMEM_DATA_W    = 32;
  localparam int CONFLICT_CNT_W = 16;

  // Owner of an access travelling down the read-return pipeline.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  // Encoding of the "granted most recently" pointer (req/gnt bit index).
  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_EXT  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Bit 0 = core, bit 1 = external port.
// Purely combinational; the last-granted pointer is held by the parent.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the port that did not win most recently takes the slot.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last == LAST_EXT))
      gnt = 2'b01;
    else if (req[1])
      gnt = 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store port and
// the external loader/debug port. Registered memory-side outputs, read data
// routed back to its requester by a two-stage owner tag.
// Optional build macro: DMEM_ARB_STATS_EN adds a saturating conflict counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_stall,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  logic [1:0]        req, pick, gnt;
  logic              last_q, last_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  owner_t            tag1_q, tag1_d;
  owner_t            tag2_q, tag2_d;

  assign req = {ext_req, core_req};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  // Grants are suppressed while reset is asserted.
  always_comb begin
    gnt = reset ? 2'b00 : pick;
  end

  assign core_gnt   = gnt[0];
  assign ext_gnt    = gnt[1];
  assign core_stall = core_req & ~gnt[0];
  assign ext_stall  = ext_req & ~gnt[1];

  // Next-state for the memory command registers, owner tags and pointer.
  // Writes enter the tag pipe as NONE so they never raise rvalid.
  always_comb begin
    last_d      = last_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag1_d      = OWN_NONE;
    tag2_d      = tag1_q;
    if (gnt[0]) begin
      last_d      = LAST_CORE;
      mem_wr_d    = core_we;
      mem_rd_d    = ~core_we;
      mem_addr_d  = core_addr;
      mem_wdata_d = core_wdata;
      tag1_d      = core_we ? OWN_NONE : OWN_CORE;
    end else if (gnt[1]) begin
      last_d      = LAST_EXT;
      mem_wr_d    = ext_we;
      mem_rd_d    = ~ext_we;
      mem_addr_d  = ext_addr;
      mem_wdata_d = ext_wdata;
      tag1_d      = ext_we ? OWN_NONE : OWN_EXT;
    end
  end

  // State registers; reset drops in-flight tags so stale reads never return.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= LAST_EXT;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag1_q      <= OWN_NONE;
      tag2_q      <= OWN_NONE;
    end else begin
      last_q      <= last_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wdata_q;

  assign core_rvalid = (tag2_q == OWN_CORE);
  assign ext_rvalid  = (tag2_q == OWN_EXT);
  assign core_rdata  = core_rvalid ? mem_rd_data : '0;
  assign ext_rdata   = ext_rvalid ? mem_rd_data : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [CONFLICT_CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles with both ports requesting; stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (core_req && ext_req && (cnt_q != '1))
      cnt_d = cnt_q + CONFLICT_CNT_W'(1);
  end

  // Conflict counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
